cache_req_arbiter: RTL and testbench
====================================

Name: cache_req_arbiter

Overview:
- Sits between the two processor request ports and the single shared cache request/response port.
- Buffers each processor's 22-bit request in a small per-requester FIFO and grants the cache round-robin, one outstanding transaction at a time.
- Routes each cache response back to the requester that issued it, and recovers from lost responses with a timeout.

Parameters:
REQ_W, 22, request/response word width: [21] pid, [20] load(0)/store(1), [19:9] tag, [8] block offset, [7:0] data
FIFO_DEPTH, 2, entries per requester FIFO (power of 2, >=2)
TIMEOUT, 15, max cycles in WAIT_RESP before abort (>=1)

Ports:
clk  in  1  the single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
p0_req_valid  in  1  P0 request valid
p0_req  in  REQ_W  P0 request word
p0_req_ready  out  1  P0 FIFO not full
p1_req_valid  in  1  P1 request valid
p1_req  in  REQ_W  P1 request word
p1_req_ready  out  1  P1 FIFO not full
cache_req_valid  out  1  request presented to cache
cache_req  out  REQ_W  request word to cache
cache_busy  in  1  cache cannot accept this cycle
cache_resp_valid  in  1  cache response valid (1-cycle pulse)
cache_resp  in  REQ_W  cache response word
p0_resp_valid  out  1  response pulse to P0
p0_resp  out  REQ_W  response word to P0
p1_resp_valid  out  1  response pulse to P1
p1_resp  out  REQ_W  response word to P1
timeout_err  out  1  1-cycle pulse on aborted transaction

Behaviour:
- Reset (rst_n low, async):
  - FIFOs empty; state IDLE; last_grant = 1, so P0 wins the first tie.
  - Timeout counter 0.
  - All valid outputs and timeout_err 0; all word outputs 0.
  - p*_req_ready = 1 once reset is released.
- Enqueue:
  - A push occurs on a rising edge when px_req_valid && px_req_ready.
  - px_req_ready = !full, combinational from FIFO count only.
  - A push and a pop of the same FIFO in one cycle are both legal; count is unchanged.
- FSM states: IDLE, ISSUE, WAIT_RESP.
  - IDLE, both FIFOs empty: stay in IDLE.
  - IDLE, exactly one FIFO non-empty: grant that requester.
  - IDLE, both non-empty: grant !last_grant.
  - On any grant: latch grant id, update last_grant, go to ISSUE.
- ISSUE:
  - cache_req_valid = 1.
  - cache_req = FIFO head with bit [21] forced to the grant id.
  - On an edge with !cache_busy: pop the granted FIFO, clear the timeout counter, go to WAIT_RESP.
  - While cache_busy = 1: hold state and hold cache_req stable.
- WAIT_RESP:
  - cache_req_valid = 0; counter increments each cycle.
  - If cache_resp_valid is seen:
    - Next cycle, p{grant}_resp_valid = 1 for exactly one cycle.
    - p{grant}_resp = cache_resp, registered.
    - Return to IDLE.
  - Routing uses the latched grant id, not cache_resp[21].
  - If the counter reaches TIMEOUT with no response: timeout_err pulses one cycle, the transaction is dropped (no resp pulse), go to IDLE.
- Latency:
  - Request pushed at edge N, FIFO previously empty, arbiter idle: cache_req_valid is high in the cycle after edge N+1.
  - Response delivered one cycle after cache_resp_valid.
- cache_resp_valid while in IDLE or ISSUE is ignored; no output changes.
- p*_resp hold their last value when p*_resp_valid = 0.
- Mid-operation reset: state, FIFO contents and an outstanding transaction are all discarded immediately; no response pulse is produced.

Test Plan:
- Single P0 load 22'h0A0100, cache_busy = 0, cache returns 22'h0A01AB 2 cycles after issue:
  - cache_req = 22'h0A0100 one cycle.
  - p0_resp_valid pulses once with 22'h0A01AB.
  - p1_resp_valid stays 0.
- P0 and P1 push on the same edge; cache responds after 1 cycle:
  - Issue order P0, then P1.
  - Next simultaneous pair is issued P0, then P1 again (alternation from last_grant = 1).
  - The P1 issue carries bit [21] = 1.
- P1 pushes 3 back-to-back requests with FIFO_DEPTH = 2 while cache_busy = 1:
  - p1_req_ready drops after the 2nd push; the 3rd is held.
  - Releasing cache_busy drains them in order; the 3rd is accepted.
- Hold cache_busy = 1 for 5 cycles during ISSUE:
  - cache_req_valid stays high and cache_req stays constant.
  - Pop occurs only on the release edge.
- Withhold the response for 15 cycles:
  - timeout_err pulses once; no p*_resp_valid.
  - FSM returns to IDLE.
  - A late cache_resp_valid afterwards is ignored.
- Assert rst_n = 0 during WAIT_RESP with P1 FIFO holding 1 entry:
  - All valids drop asynchronously; FIFO is empty after release.
  - The next request issues normally.

Source files
------------

// File: rtl/cache_req_arbiter_if.sv
// Processor request/response ports and shared cache port of the
// two-requester cache arbiter.
interface cache_req_arbiter_if #(
   parameter int REQ_W = 22
);
   logic             p0_req_valid;
   logic [REQ_W-1:0] p0_req;
   logic             p0_req_ready;
   logic             p1_req_valid;
   logic [REQ_W-1:0] p1_req;
   logic             p1_req_ready;
   logic             cache_req_valid;
   logic [REQ_W-1:0] cache_req;
   logic             cache_busy;
   logic             cache_resp_valid;
   logic [REQ_W-1:0] cache_resp;
   logic             p0_resp_valid;
   logic [REQ_W-1:0] p0_resp;
   logic             p1_resp_valid;
   logic [REQ_W-1:0] p1_resp;
   logic             timeout_err;

   modport slave (
      input  p0_req_valid, p0_req,
      input  p1_req_valid, p1_req,
      input  cache_busy, cache_resp_valid, cache_resp,
      output p0_req_ready, p1_req_ready,
      output cache_req_valid, cache_req,
      output p0_resp_valid, p0_resp,
      output p1_resp_valid, p1_resp,
      output timeout_err
   );

   modport master (
      output p0_req_valid, p0_req,
      output p1_req_valid, p1_req,
      output cache_busy, cache_resp_valid, cache_resp,
      input  p0_req_ready, p1_req_ready,
      input  cache_req_valid, cache_req,
      input  p0_resp_valid, p0_resp,
      input  p1_resp_valid, p1_resp,
      input  timeout_err
   );
endinterface

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter of two processor request FIFOs onto one cache
// port; one outstanding transaction, responses routed by latched grant.
module cache_req_arbiter #(
   parameter int REQ_W      = 22,
   parameter int FIFO_DEPTH = 2,
   parameter int TIMEOUT    = 15
) (
   input logic                clk,
   input logic                rst_n,
   cache_req_arbiter_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_e;

   state_e           state_q, state_d;
   logic             grant_q, grant_d;
   logic             last_q, last_d;
   logic [TW-1:0]    tmo_q, tmo_d;

   logic [REQ_W-1:0] mem_q [2][FIFO_DEPTH];
   logic [AW-1:0]    wp_q [2];
   logic [AW-1:0]    rp_q [2];
   logic [CW-1:0]    cnt_q [2];
   logic [REQ_W-1:0] req_in [2];
   logic [REQ_W-1:0] head [2];
   logic [1:0]       push, pop, full, nempty;

   logic             issue_go, rsp_fire, tmo_fire;
   logic             req_v;
   logic [REQ_W-1:0] req_w;
   logic             p0_rv_q, p1_rv_q, terr_q;
   logic [REQ_W-1:0] p0_resp_q, p1_resp_q;

   assign req_in[0] = bus.p0_req;
   assign req_in[1] = bus.p1_req;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         full[i]   = cnt_q[i] == CW'(FIFO_DEPTH);
         nempty[i] = cnt_q[i] != '0;
         head[i]   = mem_q[i][rp_q[i]];
      end
   end

   assign push[0] = bus.p0_req_valid & ~full[0];
   assign push[1] = bus.p1_req_valid & ~full[1];
   assign pop[0]  = issue_go & ~grant_q;
   assign pop[1]  = issue_go & grant_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            wp_q[i]  <= '0;
            rp_q[i]  <= '0;
            cnt_q[i] <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++)
               mem_q[i][j] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
               mem_q[i][wp_q[i]] <= req_in[i];
               wp_q[i]           <= wp_q[i] + 1'b1;
            end
            if (pop[i])
               rp_q[i] <= rp_q[i] + 1'b1;
            if (push[i] != pop[i])
               cnt_q[i] <= push[i] ? cnt_q[i] + 1'b1
                                   : cnt_q[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         IDLE: begin
            if (|nempty) begin
               // Tie goes to whoever was not granted last.
               grant_d = (&nempty) ? ~last_q : nempty[1];
               last_d  = grant_d;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (!bus.cache_busy) begin
               tmo_d   = '0;
               state_d = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            if (bus.cache_resp_valid || tmo_q == TW'(TIMEOUT - 1)) begin
               tmo_d   = '0;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_v    = 1'b0;
      req_w    = '0;
      issue_go = 1'b0;
      rsp_fire = 1'b0;
      tmo_fire = 1'b0;
      unique case (state_q)
         ISSUE: begin
            req_v            = 1'b1;
            req_w            = head[grant_q];
            req_w[REQ_W-1]   = grant_q;
            issue_go         = ~bus.cache_busy;
         end
         WAIT_RESP: begin
            rsp_fire = bus.cache_resp_valid;
            tmo_fire = ~bus.cache_resp_valid &
                       (tmo_q == TW'(TIMEOUT - 1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_rv_q   <= 1'b0;
         p1_rv_q   <= 1'b0;
         terr_q    <= 1'b0;
         p0_resp_q <= '0;
         p1_resp_q <= '0;
      end else begin
         p0_rv_q <= rsp_fire & ~grant_q;
         p1_rv_q <= rsp_fire & grant_q;
         terr_q  <= tmo_fire;
         if (rsp_fire & ~grant_q)
            p0_resp_q <= bus.cache_resp;
         if (rsp_fire & grant_q)
            p1_resp_q <= bus.cache_resp;
      end
   end

   assign bus.p0_req_ready    = ~full[0];
   assign bus.p1_req_ready    = ~full[1];
   assign bus.cache_req_valid = req_v;
   assign bus.cache_req       = req_w;
   assign bus.p0_resp_valid   = p0_rv_q;
   assign bus.p0_resp         = p0_resp_q;
   assign bus.p1_resp_valid   = p1_rv_q;
   assign bus.p1_resp         = p1_resp_q;
   assign bus.timeout_err     = terr_q;
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: arbitration order, FIFO
// back-pressure, busy hold, timeout and mid-transaction reset.
module tb_cache_req_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   cache_req_arbiter_if bus ();

   cache_req_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not terminate");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait for an issue, check it, accept it, answer in the first wait cycle.
   task automatic serve(input logic [21:0] exp_req,
                        input logic [21:0] rsp, input int pid);
      bus.cache_busy = 1'b0;
      for (int i = 0; i < 8 && !bus.cache_req_valid; i++) tick();
      chk("issue_seen", bus.cache_req_valid, 1);
      chk("issue_word", bus.cache_req, exp_req);
      tick();
      chk("issue_drop", bus.cache_req_valid, 0);
      bus.cache_resp_valid = 1'b1;
      bus.cache_resp       = rsp;
      tick();
      bus.cache_resp_valid = 1'b0;
      chk("rsp_p0_v", bus.p0_resp_valid, (pid == 0) ? 1 : 0);
      chk("rsp_p1_v", bus.p1_resp_valid, (pid == 1) ? 1 : 0);
      chk("rsp_word", (pid == 0) ? bus.p0_resp : bus.p1_resp, rsp);
      tick();
      chk("rsp_pulse_end", bus.p0_resp_valid | bus.p1_resp_valid, 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.p0_req_valid     = 1'b0;
      bus.p0_req           = '0;
      bus.p1_req_valid     = 1'b0;
      bus.p1_req           = '0;
      bus.cache_busy       = 1'b0;
      bus.cache_resp_valid = 1'b0;
      bus.cache_resp       = '0;

      #12;
      chk("rst_creq_v", bus.cache_req_valid, 0);
      chk("rst_creq", bus.cache_req, 0);
      chk("rst_rsp_v", {bus.p0_resp_valid, bus.p1_resp_valid}, 0);
      chk("rst_rsp", {bus.p0_resp, bus.p1_resp}, 0);
      chk("rst_terr", bus.timeout_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", {bus.p0_req_ready, bus.p1_req_ready}, 2'b11);

      // Simultaneous pair: P0 first, bit 21 forced on P1 issue
      bus.p0_req_valid = 1'b1;
      bus.p0_req       = 22'h011111;
      bus.p1_req_valid = 1'b1;
      bus.p1_req       = 22'h022222;
      tick();
      bus.p0_req_valid = 1'b0;
      bus.p1_req_valid = 1'b0;
      serve(22'h011111, 22'h2000A1, 0);
      serve(22'h222222, 22'h0000B2, 1);

      bus.p0_req_valid = 1'b1;
      bus.p0_req       = 22'h033333;
      bus.p1_req_valid = 1'b1;
      bus.p1_req       = 22'h044444;
      tick();
      bus.p0_req_valid = 1'b0;
      bus.p1_req_valid = 1'b0;
      serve(22'h033333, 22'h0000C3, 0);
      serve(22'h244444, 22'h2000D4, 1);

      // Single P0 load, exact latency
      bus.p0_req_valid = 1'b1;
      bus.p0_req       = 22'h0A0100;
      tick();
      bus.p0_req_valid = 1'b0;
      chk("t1_not_yet", bus.cache_req_valid, 0);
      tick();
      chk("t1_issue_v", bus.cache_req_valid, 1);
      chk("t1_issue", bus.cache_req, 22'h0A0100);
      tick();
      chk("t1_one_cycle", bus.cache_req_valid, 0);
      tick();
      bus.cache_resp_valid = 1'b1;
      bus.cache_resp       = 22'h0A01AB;
      tick();
      bus.cache_resp_valid = 1'b0;
      chk("t1_p0_v", bus.p0_resp_valid, 1);
      chk("t1_p0", bus.p0_resp, 22'h0A01AB);
      chk("t1_p1_v", bus.p1_resp_valid, 0);
      tick();
      chk("t1_p0_end", bus.p0_resp_valid, 0);
      chk("t1_p0_hold", bus.p0_resp, 22'h0A01AB);

      // P1 back-pressure while the cache is busy
      bus.cache_busy   = 1'b1;
      bus.p1_req_valid = 1'b1;
      bus.p1_req       = 22'h010001;
      tick();
      chk("t3_rdy1", bus.p1_req_ready, 1);
      bus.p1_req = 22'h010002;
      tick();
      chk("t3_rdy2", bus.p1_req_ready, 0);
      bus.p1_req = 22'h010003;
      tick();
      chk("t3_rdy3", bus.p1_req_ready, 0);
      chk("t3_head", bus.cache_req, 22'h210001);
      bus.cache_busy = 1'b0;
      tick();
      chk("t3_rdy_pop", bus.p1_req_ready, 1);
      bus.cache_resp_valid = 1'b1;
      bus.cache_resp       = 22'h2001E1;
      tick();
      bus.cache_resp_valid = 1'b0;
      bus.p1_req_valid     = 1'b0;
      chk("t3_r1_v", bus.p1_resp_valid, 1);
      chk("t3_r1", bus.p1_resp, 22'h2001E1);
      chk("t3_full_again", bus.p1_req_ready, 0);
      serve(22'h210002, 22'h2001E2, 1);
      serve(22'h210003, 22'h2001E3, 1);

      // Busy held for five cycles during ISSUE
      bus.cache_busy   = 1'b1;
      bus.p0_req_valid = 1'b1;
      bus.p0_req       = 22'h055555;
      tick();
      bus.p0_req_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_v", bus.cache_req_valid, 1);
         chk("t4_hold", bus.cache_req, 22'h055555);
         tick();
      end
      chk("t4_still_v", bus.cache_req_valid, 1);
      bus.cache_busy = 1'b0;
      tick();
      chk("t4_popped", bus.cache_req_valid, 0);
      bus.cache_resp_valid = 1'b1;
      bus.cache_resp       = 22'h0000F5;
      tick();
      bus.cache_resp_valid = 1'b0;
      chk("t4_rsp", bus.p0_resp, 22'h0000F5);

      // Timeout after 15 cycles in WAIT_RESP
      bus.p0_req_valid = 1'b1;
      bus.p0_req       = 22'h066666;
      tick();
      bus.p0_req_valid = 1'b0;
      tick();
      chk("t5_issue", bus.cache_req, 22'h066666);
      tick();
      for (int i = 0; i < 14; i++) begin
         chk("t5_no_terr", bus.timeout_err, 0);
         tick();
      end
      chk("t5_no_terr_last", bus.timeout_err, 0);
      tick();
      chk("t5_terr", bus.timeout_err, 1);
      chk("t5_no_rsp", {bus.p0_resp_valid, bus.p1_resp_valid}, 0);
      tick();
      chk("t5_terr_end", bus.timeout_err, 0);
      bus.cache_resp_valid = 1'b1;
      bus.cache_resp       = 22'h3FFFFF;
      tick();
      bus.cache_resp_valid = 1'b0;
      chk("t5_late_v", {bus.p0_resp_valid, bus.p1_resp_valid}, 0);
      chk("t5_late_w", bus.p0_resp, 22'h0000F5);
      chk("t5_idle", bus.cache_req_valid, 0);

      // Reset during WAIT_RESP with one P1 entry queued
      bus.p0_req_valid = 1'b1;
      bus.p0_req       = 22'h077777;
      tick();
      bus.p0_req_valid = 1'b0;
      tick();
      bus.p1_req_valid = 1'b1;
      bus.p1_req       = 22'h088888;
      tick();
      bus.p1_req_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #2;
      chk("t6_rst_v", {bus.cache_req_valid, bus.p0_resp_valid,
                       bus.p1_resp_valid, bus.timeout_err}, 0);
      chk("t6_rst_w", bus.p0_resp, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.cache_resp_valid = 1'b1;
      bus.cache_resp       = 22'h012345;
      tick();
      bus.cache_resp_valid = 1'b0;
      chk("t6_no_rsp", {bus.p0_resp_valid, bus.p1_resp_valid}, 0);
      for (int i = 0; i < 3; i++) begin
         chk("t6_fifo_empty", bus.cache_req_valid, 0);
         tick();
      end
      bus.p1_req_valid = 1'b1;
      bus.p1_req       = 22'h099999;
      tick();
      bus.p1_req_valid = 1'b0;
      serve(22'h299999, 22'h0ABCDE, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
